// File: rtl/int_ctrl_pkg.sv
// Shared definitions for the interrupt controller: FSM encoding,
// the default source count and the symbolic source indices.
package int_ctrl_pkg;

  // Handshake FSM encoding
  typedef enum logic [1:0] {
    IDLE    = 2'b00,
    REQ     = 2'b01,
    SERVICE = 2'b10
  } state_t;

  // Default number of interrupt sources (Sw0..Sw3, North_Button)
  localparam int DEFAULT_NUM_SRC = 5;

  // Source indices; a lower index means a higher priority
  localparam int SRC_SW0   = 0;
  localparam int SRC_SW1   = 1;
  localparam int SRC_SW2   = 2;
  localparam int SRC_SW3   = 3;
  localparam int SRC_NORTH = 4;

endpackage : int_ctrl_pkg

// File: rtl/interrupt_controller_if.sv
// Signal bundle between the interrupt controller, the interrupt register
// and the control unit. The controller connects through the slave modport;
// the master modport is the view of the surrounding processor logic.
interface interrupt_controller_if
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC,
  parameter int ADDR_W  = 16
) ();

  // Interrupt register side
  logic [NUM_SRC-1:0] Src_State;
  logic [NUM_SRC-1:0] Mask_Data;
  logic               Mask_Write;
  logic               Clear_Write;
  logic [NUM_SRC-1:0] Clear_Sel;
  logic [NUM_SRC-1:0] Pending;

  // Control unit side
  logic               Int_Ack;
  logic               Int_Done;
  logic               Irq;
  logic [2:0]         Int_Id;
  logic [ADDR_W-1:0]  Int_Vector;
  logic               In_Service;

  modport slave (
    input  Src_State, Mask_Data, Mask_Write, Int_Ack, Int_Done,
    output Irq, Int_Id, Int_Vector, In_Service, Clear_Write, Clear_Sel, Pending
  );

  modport master (
    output Src_State, Mask_Data, Mask_Write, Int_Ack, Int_Done,
    input  Irq, Int_Id, Int_Vector, In_Service, Clear_Write, Clear_Sel, Pending
  );

endinterface : interrupt_controller_if

// File: rtl/int_priority_enc.sv
// Combinational fixed-priority encoder: the lowest set index wins.
module int_priority_enc
  import int_ctrl_pkg::*;
#(
  parameter int NUM_SRC = DEFAULT_NUM_SRC
) (
  input  logic [NUM_SRC-1:0] req,
  output logic               valid,
  output logic [2:0]         idx
);

  // Scan from the highest index down so the lowest set index is written last
  always_comb begin
    // NOTE: every output gets a default before the loop; without it a
    // combinational block that only assigns conditionally infers a latch.
    valid = 1'b0;
    idx   = '0;
    for (int i = NUM_SRC - 1; i >= 0; i--) begin
      if (req[i]) begin
        valid = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule : int_priority_enc

// File: rtl/interrupt_controller.sv
// Interrupt controller: edge-detects the source state bits into pending
// flags, gates them with a software mask, picks the highest-priority
// request and runs the request/acknowledge/done handshake with the
// control unit. On acknowledge it pulses a clear back to the interrupt
// register for the serviced source.
module interrupt_controller
  import int_ctrl_pkg::*;
#(
  parameter int                NUM_SRC       = DEFAULT_NUM_SRC,
  parameter int                ADDR_W        = 16,
  parameter logic [ADDR_W-1:0] VECTOR_BASE   = ADDR_W'(16'h0100),
  parameter logic [ADDR_W-1:0] VECTOR_STRIDE = ADDR_W'(16'h0010)
) (
  input  logic                  CLK,
  input  logic                  CLR,
  interrupt_controller_if.slave bus
);

  state_t             state;
  state_t             next_state;

  logic [NUM_SRC-1:0] prev;        // previous Src_State sample
  logic [NUM_SRC-1:0] pending;     // raw edge-captured requests
  logic [NUM_SRC-1:0] mask;        // 1 = source may be arbitrated
  logic [NUM_SRC-1:0] edges;       // rising edges seen this cycle
  logic [NUM_SRC-1:0] active;      // pending and enabled
  logic [NUM_SRC-1:0] ack_sel;     // one-hot of the latched source

  logic               win_valid;
  logic [2:0]         win_idx;
  logic [2:0]         int_id;

  logic               latch_id;    // IDLE -> REQ: capture the winner
  logic               take_ack;    // REQ accepted this cycle

  logic               clear_write;
  logic [NUM_SRC-1:0] clear_sel;

  assign edges   = bus.Src_State & ~prev;
  assign active  = pending & mask;
  assign ack_sel = NUM_SRC'(1) << int_id;

  int_priority_enc #(
    .NUM_SRC (NUM_SRC)
  ) u_priority_enc (
    .req   (active),
    .valid (win_valid),
    .idx   (win_idx)
  );

  // Handshake state register
  always_ff @(posedge CLK or negedge CLR) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples the pre-edge values regardless of block order.
    if (!CLR) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic and one-cycle control decodes for the handshake
  always_comb begin
    next_state = state;
    latch_id   = 1'b0;
    take_ack   = 1'b0;
    case (state)
      IDLE: begin
        if (win_valid) begin
          latch_id   = 1'b1;
          next_state = REQ;
        end
      end
      REQ: begin
        // The latched request stays up even if its mask bit drops here
        if (bus.Int_Ack) begin
          take_ack   = 1'b1;
          next_state = SERVICE;
        end
      end
      SERVICE: begin
        // No nesting: anything newly pending waits for Int_Done
        if (bus.Int_Done) begin
          next_state = IDLE;
        end
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Edge capture, pending bookkeeping and mask register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      prev    <= '0;
      pending <= '0;
      mask    <= '0;
    end else begin
      prev <= bus.Src_State;
      // A fresh edge on the acknowledged source re-arms it: set wins
      pending <= (pending & ~({NUM_SRC{take_ack}} & ack_sel)) | edges;
      if (bus.Mask_Write) begin
        mask <= bus.Mask_Data;
      end
    end
  end

  // Latched source id and the clear strobe toward the interrupt register
  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      int_id      <= '0;
      clear_write <= 1'b0;
      clear_sel   <= '0;
    end else begin
      clear_write <= take_ack;
      if (latch_id) begin
        int_id <= win_idx;
      end
      if (take_ack) begin
        clear_sel <= ack_sel;
      end
    end
  end

  // All outputs come from registers or decodes of registered state
  assign bus.Irq         = (state == REQ);
  assign bus.In_Service  = (state == SERVICE);
  assign bus.Int_Id      = int_id;
  assign bus.Int_Vector  = VECTOR_BASE + ADDR_W'(int_id) * VECTOR_STRIDE;
  assign bus.Clear_Write = clear_write;
  assign bus.Clear_Sel   = clear_sel;
  assign bus.Pending     = pending;

endmodule : interrupt_controller

// File: tb/tb_interrupt_controller.sv
// Self-checking bench for interrupt_controller. Expected requests
// (source id and handler address) are queued when a source is stimulated
// and compared when the controller raises Irq.
module tb_interrupt_controller;
  import int_ctrl_pkg::*;

  localparam int NSRC = 5;
  localparam int AW   = 16;

  typedef struct {
    logic [2:0]    id;
    logic [AW-1:0] vec;
  } exp_t;

  logic CLK;
  logic CLR;

  interrupt_controller_if #(.NUM_SRC(NSRC), .ADDR_W(AW)) bus ();

  interrupt_controller #(
    .NUM_SRC       (NSRC),
    .ADDR_W        (AW),
    .VECTOR_BASE   (16'h0100),
    .VECTOR_STRIDE (16'h0010)
  ) dut (
    .CLK (CLK),
    .CLR (CLR),
    .bus (bus)
  );

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got=running exp=finished");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic push_exp(input logic [2:0] id, input logic [AW-1:0] vec);
    exp_t e;
    e.id  = id;
    e.vec = vec;
    sb.push_back(e);
  endtask

  // Wait (bounded) for Irq, then compare against the oldest expectation
  task automatic wait_irq(input string tag, input int budget);
    exp_t e;
    for (int i = 0; i < budget && !bus.Irq; i++) step();
    check({tag, "_irq"}, 32'(bus.Irq), 32'd1);
    if (sb.size() == 0) begin
      check({tag, "_sb_empty"}, 32'(sb.size()), 32'd1);
    end else begin
      e = sb.pop_front();
      check({tag, "_id"},  32'(bus.Int_Id),     32'(e.id));
      check({tag, "_vec"}, 32'(bus.Int_Vector), 32'(e.vec));
    end
  endtask

  task automatic write_mask(input logic [NSRC-1:0] m);
    bus.Mask_Data  = m;
    bus.Mask_Write = 1'b1;
    step();
    bus.Mask_Write = 1'b0;
  endtask

  task automatic do_ack(input string tag, input logic [NSRC-1:0] sel, input logic [NSRC-1:0] pend);
    bus.Int_Ack = 1'b1;
    step();
    bus.Int_Ack = 1'b0;
    check({tag, "_ack_irq"},  32'(bus.Irq),         32'd0);
    check({tag, "_ack_insv"}, 32'(bus.In_Service),  32'd1);
    check({tag, "_ack_clrw"}, 32'(bus.Clear_Write), 32'd1);
    check({tag, "_ack_csel"}, 32'(bus.Clear_Sel),   32'(sel));
    check({tag, "_ack_pend"}, 32'(bus.Pending),     32'(pend));
    step();
    check({tag, "_clrw_drop"}, 32'(bus.Clear_Write), 32'd0);
  endtask

  task automatic do_done(input string tag);
    bus.Int_Done = 1'b1;
    step();
    bus.Int_Done = 1'b0;
    check({tag, "_done_insv"}, 32'(bus.In_Service), 32'd0);
    check({tag, "_done_irq"},  32'(bus.Irq),        32'd0);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_irq"},  32'(bus.Irq),         32'd0);
    check({tag, "_insv"}, 32'(bus.In_Service),  32'd0);
    check({tag, "_clrw"}, 32'(bus.Clear_Write), 32'd0);
    check({tag, "_csel"}, 32'(bus.Clear_Sel),   32'd0);
    check({tag, "_id"},   32'(bus.Int_Id),      32'd0);
    check({tag, "_vec"},  32'(bus.Int_Vector),  32'h0100);
    check({tag, "_pend"}, 32'(bus.Pending),     32'd0);
  endtask

  initial begin
    bus.Src_State  = '0;
    bus.Mask_Data  = '0;
    bus.Mask_Write = 1'b0;
    bus.Int_Ack    = 1'b0;
    bus.Int_Done   = 1'b0;
    CLR            = 1'b1;
    #3 CLR = 1'b0;
    #5;
    check_reset_outputs("reset");
    @(negedge CLK);
    CLR = 1'b1;
    step();

    // Single Sw0 request: pending at edge k, Irq after edge k+1
    write_mask(5'b11111);
    bus.Src_State = 5'b00001;
    push_exp(3'(SRC_SW0), 16'h0100);
    step();
    check("t1_pend", 32'(bus.Pending), 32'h01);
    check("t1_irq_lat1", 32'(bus.Irq), 32'd0);
    step();
    check("t1_irq_lat2", 32'(bus.Irq), 32'd1);
    wait_irq("t1", 1);
    do_ack("t1", 5'b00001, 5'b00000);
    do_done("t1");
    bus.Src_State = '0;
    step();

    // Sw2 and North together: Sw2 first, North after Done
    bus.Src_State = 5'b10100;
    push_exp(3'(SRC_SW2), 16'h0120);
    push_exp(3'(SRC_NORTH), 16'h0140);
    wait_irq("t2a", 10);
    do_ack("t2a", 5'b00100, 5'b10000);
    do_done("t2a");
    step();
    check("t2_next_irq_lat", 32'(bus.Irq), 32'd1);
    wait_irq("t2b", 10);
    do_ack("t2b", 5'b10000, 5'b00000);
    do_done("t2b");
    bus.Src_State = '0;
    step();

    // Masked North accumulates pending, unmasking raises the request
    write_mask(5'b01111);
    bus.Src_State = 5'b10000;
    repeat (4) step();
    check("t3_masked_irq", 32'(bus.Irq), 32'd0);
    check("t3_masked_pend", 32'(bus.Pending), 32'h10);
    bus.Src_State = '0;
    write_mask(5'b11111);
    push_exp(3'(SRC_NORTH), 16'h0140);
    wait_irq("t3", 10);
    do_ack("t3", 5'b10000, 5'b00000);
    do_done("t3");

    // No nesting: Sw0 during SERVICE waits for Done
    bus.Src_State = 5'b00100;
    push_exp(3'(SRC_SW2), 16'h0120);
    wait_irq("t4a", 10);
    do_ack("t4a", 5'b00100, 5'b00000);
    bus.Src_State = 5'b00101;
    push_exp(3'(SRC_SW0), 16'h0100);
    repeat (3) step();
    check("t4_nest_irq", 32'(bus.Irq), 32'd0);
    check("t4_nest_insv", 32'(bus.In_Service), 32'd1);
    check("t4_nest_pend", 32'(bus.Pending), 32'h01);
    do_done("t4a");
    wait_irq("t4b", 10);
    do_ack("t4b", 5'b00001, 5'b00000);
    do_done("t4b");
    bus.Src_State = '0;
    step();

    // Masking during REQ does not withdraw the latched request
    bus.Src_State = 5'b01000;
    push_exp(3'(SRC_SW3), 16'h0130);
    wait_irq("t5", 10);
    write_mask(5'b00000);
    check("t5_req_held_irq", 32'(bus.Irq), 32'd1);
    check("t5_req_held_id", 32'(bus.Int_Id), 32'd3);
    do_ack("t5", 5'b01000, 5'b00000);
    do_done("t5");
    write_mask(5'b11111);
    bus.Src_State = '0;
    step();

    // Stray Ack in IDLE and Done in REQ are ignored
    bus.Int_Ack = 1'b1;
    step();
    bus.Int_Ack = 1'b0;
    check("t6_stray_ack_insv", 32'(bus.In_Service), 32'd0);
    check("t6_stray_ack_clrw", 32'(bus.Clear_Write), 32'd0);
    bus.Src_State = 5'b00010;
    push_exp(3'(SRC_SW1), 16'h0110);
    wait_irq("t6", 10);
    bus.Int_Done = 1'b1;
    step();
    bus.Int_Done = 1'b0;
    check("t6_stray_done_irq", 32'(bus.Irq), 32'd1);
    check("t6_stray_done_insv", 32'(bus.In_Service), 32'd0);
    bus.Int_Ack = 1'b1;
    step();
    bus.Int_Ack = 1'b0;
    check("t6_svc_insv", 32'(bus.In_Service), 32'd1);

    // Asynchronous reset during SERVICE
    CLR = 1'b0;
    #1;
    check_reset_outputs("t7_rst");
    bus.Src_State = '0;
    repeat (2) begin
      step();
      check("t7_rst_clrw", 32'(bus.Clear_Write), 32'd0);
    end
    @(negedge CLK);
    CLR = 1'b1;
    step();
    check("t7_post_clrw", 32'(bus.Clear_Write), 32'd0);
    check("t7_post_irq", 32'(bus.Irq), 32'd0);
    write_mask(5'b11111);

    // Re-edge on the acknowledged source in the ack cycle keeps it pending
    bus.Src_State = 5'b00001;
    push_exp(3'(SRC_SW0), 16'h0100);
    wait_irq("t8a", 10);
    bus.Src_State = '0;
    step();
    check("t8_req_hold", 32'(bus.Irq), 32'd1);
    bus.Src_State = 5'b00001;
    push_exp(3'(SRC_SW0), 16'h0100);
    do_ack("t8a", 5'b00001, 5'b00001);
    do_done("t8a");
    wait_irq("t8b", 10);
    do_ack("t8b", 5'b00001, 5'b00000);
    do_done("t8b");

    check("sb_drained", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule : tb_interrupt_controller
